fifo_write_logic: RTL and testbench

Write-side pointer and flag logic of the router's asynchronous port FIFO. It tracks the binary/Gray write pointer, synchronises the read pointer's Gray code into the write clock domain, and produces full, almost-full, occupancy and overflow indications. It also generates the RAM write enable and address. It drives the same shared FIFO RAM whose read side is serviced by `fifo_read_logic`, and exchanges Gray pointers with it.

---
 rtl/fifo_pkg.sv | 41 ++++
 rtl/fifo_write_logic_if.sv | 40 ++++
 rtl/fifo_write_logic_gray_ptr_sync.sv | 41 ++++
 rtl/fifo_write_logic.sv | 92 +++++++++
 tb/tb_fifo_write_logic.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for the asynchronous port FIFO pointer
//               logic (write and read sides). Holds the default pointer width
//               and the Gray-code helpers both clock domains must agree on.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int PTR_SZ_DEFAULT = 2;

    // Binary to Gray. Operands are zero-extended to 32 bits by the caller and
    // truncated back afterwards, so one function serves every pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above
    // it. Zero upper bits contribute nothing, so zero-extension is harmless.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 1; i < 32; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

    // Pattern the write Gray pointer takes when the FIFO is full relative to
    // a read Gray pointer: the two most significant bits inverted. For a
    // 2-bit pointer (ptr_sz = 1) this inverts both bits.
    function automatic logic [31:0] gray_full_pattern(input logic [31:0] gray,
                                                      input int          ptr_sz);
        logic [31:0] mask;
        mask = 32'd3 << (ptr_sz - 1);
        return gray ^ mask;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_write_logic_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_logic_if
// Description : Write-side FIFO bundle: write request, read Gray pointer from
//               the read domain, overflow clear, and the RAM strobe/address,
//               Gray write pointer, flags and occupancy returned.
//   master : drives winc, rgray, wovf_clr
//   slave  : drives write_en, waddr, waddr_gray, wfull, walmost_full,
//            wcount, wovf
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_write_logic_if
    import fifo_pkg::*;
#(
    parameter int PTR_SZ = PTR_SZ_DEFAULT
) ();

    logic              winc;
    logic [PTR_SZ:0]   rgray;
    logic              wovf_clr;
    logic              write_en;
    logic [PTR_SZ-1:0] waddr;
    logic [PTR_SZ:0]   waddr_gray;
    logic              wfull;
    logic              walmost_full;
    logic [PTR_SZ:0]   wcount;
    logic              wovf;

    modport master (
        output winc, rgray, wovf_clr,
        input  write_en, waddr, waddr_gray, wfull, walmost_full, wcount, wovf
    );

    modport slave (
        input  winc, rgray, wovf_clr,
        output write_en, waddr, waddr_gray, wfull, walmost_full, wcount, wovf
    );

endinterface : fifo_write_logic_if
`default_nettype wire

// File: rtl/fifo_write_logic_gray_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : gray_ptr_sync
// Description : Multi-flop synchroniser for a Gray-coded pointer crossing
//               into the local clock domain. The input feeds the first flop
//               directly with no logic in front of it.
//   clk  in  : destination-domain clock
//   rst  in  : synchronous active-high reset, clears every stage
//   i_d  in  : Gray pointer from the other domain
//   o_q  out : synchronised pointer (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module gray_ptr_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : gray_ptr_sync
`default_nettype wire

// File: rtl/fifo_write_logic.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_logic
// Description : Write-side pointer and flag logic of the asynchronous port
//               FIFO. Keeps the binary/Gray write pointer, brings the read
//               Gray pointer into the write domain, and produces full,
//               almost-full, occupancy and sticky overflow, plus the RAM
//               write strobe and address.
//   clk  in    : write-domain clock
//   rst  in    : synchronous active-high reset
//   wif  slave : winc/rgray/wovf_clr in; write_en, waddr, waddr_gray, wfull,
//                walmost_full, wcount, wovf out
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_logic
    import fifo_pkg::*;
#(
    parameter int PTR_SZ      = PTR_SZ_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fifo_write_logic_if.slave  wif
);

    localparam int              c_W        = PTR_SZ + 1;
    localparam logic [PTR_SZ:0] c_AF_LEVEL = c_W'(AF_LEVEL);

    logic [PTR_SZ:0] r_wbin;
    logic [PTR_SZ:0] r_wgray;
    logic            r_wfull;
    logic            r_wovf;

    logic            w_accept;
    logic [PTR_SZ:0] w_wbin_next;
    logic [PTR_SZ:0] w_wgray_next;
    logic [PTR_SZ:0] w_wq_rgray;
    logic [PTR_SZ:0] w_wq_rbin;
    logic [PTR_SZ:0] w_full_gray;

    gray_ptr_sync #(
        .WIDTH  (c_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (clk),
        .rst (rst),
        .i_d (wif.rgray),
        .o_q (w_wq_rgray)
    );

    assign w_accept     = wif.winc && !r_wfull;
    assign w_wbin_next  = r_wbin + {{PTR_SZ{1'b0}}, w_accept};
    assign w_wgray_next = c_W'(bin2gray(32'(w_wbin_next)));
    assign w_wq_rbin    = c_W'(gray2bin(32'(w_wq_rgray)));
    assign w_full_gray  = c_W'(gray_full_pattern(32'(w_wq_rgray), PTR_SZ));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_wfull <= 1'b0;
            r_wovf  <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            // Full is judged on the post-write pointer so the write that fills
            // the last slot raises the flag on its own edge.
            r_wfull <= (w_wgray_next == w_full_gray);
            // A write attempted while full sets the flag even if a clear is
            // requested in the same cycle.
            if (wif.winc && r_wfull) begin
                r_wovf <= 1'b1;
            end else if (wif.wovf_clr) begin
                r_wovf <= 1'b0;
            end
        end
    end

    // The strobe is gated by reset so a write coinciding with reset is dropped.
    assign wif.write_en     = w_accept && !rst;
    assign wif.waddr        = r_wbin[PTR_SZ-1:0];
    assign wif.waddr_gray   = r_wgray;
    assign wif.wfull        = r_wfull;
    // Uses the lagging synchronised read pointer, so occupancy is never
    // under-reported.
    assign wif.wcount       = r_wbin - w_wq_rbin;
    assign wif.walmost_full = (wif.wcount >= c_AF_LEVEL);
    assign wif.wovf         = r_wovf;

endmodule : fifo_write_logic
`default_nettype wire

// File: tb/tb_fifo_write_logic.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_logic
// Description : Directed self-checking bench for fifo_write_logic with
//               PTR_SZ=2, SYNC_STAGES=2, AF_LEVEL=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_logic;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fifo_write_logic_if #(.PTR_SZ(2)) wif ();

    fifo_write_logic #(
        .PTR_SZ      (2),
        .SYNC_STAGES (2),
        .AF_LEVEL    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wif (wif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] gray_tbl [8];
    logic [2:0] fill_gray [4];

    initial begin
        total = 0;
        bad   = 0;
        gray_tbl  = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        fill_gray = '{3'b001, 3'b011, 3'b010, 3'b110};

        // Reset with a write request pending: strobe must be suppressed.
        rst          = 1'b1;
        wif.winc     = 1'b1;
        wif.rgray    = 3'b000;
        wif.wovf_clr = 1'b0;
        #1;
        chk("rst_write_en", 32'(wif.write_en), 32'd0);
        tick();
        chk("rst_waddr", 32'(wif.waddr), 32'd0);
        chk("rst_waddr_gray", 32'(wif.waddr_gray), 32'd0);
        chk("rst_wfull", 32'(wif.wfull), 32'd0);
        chk("rst_walmost_full", 32'(wif.walmost_full), 32'd0);
        chk("rst_wcount", 32'(wif.wcount), 32'd0);
        chk("rst_wovf", 32'(wif.wovf), 32'd0);

        // Fill four slots back to back with the read pointer at zero.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill_waddr", 32'(wif.waddr), 32'(i));
            chk("fill_write_en", 32'(wif.write_en), 32'd1);
            tick();
            chk("fill_waddr_gray", 32'(wif.waddr_gray), 32'(fill_gray[i]));
            chk("fill_wcount", 32'(wif.wcount), 32'(i + 1));
            chk("fill_walmost_full", 32'(wif.walmost_full), (i >= 2) ? 32'd1 : 32'd0);
            chk("fill_wfull", 32'(wif.wfull), (i == 3) ? 32'd1 : 32'd0);
        end

        // Write attempt while full: blocked, overflow becomes sticky.
        #1;
        chk("full_write_en", 32'(wif.write_en), 32'd0);
        tick();
        chk("full_waddr", 32'(wif.waddr), 32'd0);
        chk("full_waddr_gray", 32'(wif.waddr_gray), 32'b110);
        chk("ovf_set", 32'(wif.wovf), 32'd1);
        chk("full_hold", 32'(wif.wfull), 32'd1);
        wif.winc = 1'b0;
        tick();
        chk("ovf_held", 32'(wif.wovf), 32'd1);
        wif.wovf_clr = 1'b1;
        tick();
        chk("ovf_clr", 32'(wif.wovf), 32'd0);
        wif.wovf_clr = 1'b0;

        // One read in the read domain: full releases on the third edge.
        wif.rgray = 3'b001;
        tick();
        chk("release_e1_wfull", 32'(wif.wfull), 32'd1);
        tick();
        chk("release_e2_wfull", 32'(wif.wfull), 32'd1);
        chk("release_e2_wcount", 32'(wif.wcount), 32'd3);
        tick();
        chk("release_e3_wfull", 32'(wif.wfull), 32'd0);
        wif.winc = 1'b1;
        #1;
        chk("refill_write_en", 32'(wif.write_en), 32'd1);
        chk("refill_waddr", 32'(wif.waddr), 32'd0);
        tick();
        chk("refill_waddr_gray", 32'(wif.waddr_gray), 32'b111);
        chk("refill_wfull", 32'(wif.wfull), 32'd1);
        chk("refill_wcount", 32'(wif.wcount), 32'd4);
        wif.winc = 1'b0;

        // Fresh start, then eight writes with the reader following behind.
        wif.rgray = 3'b000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wif.winc = 1'b1;
            #1;
            chk("wrap_write_en", 32'(wif.write_en), 32'd1);
            tick();
            chk("wrap_waddr_gray", 32'(wif.waddr_gray), 32'(gray_tbl[k]));
            chk("wrap_wcount_le4", 32'(wif.wcount <= 3'd4), 32'd1);
            wif.winc  = 1'b0;
            wif.rgray = gray_tbl[k];
            tick();
            chk("wrap_idle_wcount_le4", 32'(wif.wcount <= 3'd4), 32'd1);
        end
        chk("wrap_gray_zero", 32'(wif.waddr_gray), 32'd0);

        // Let the read pointer settle, write three words, then reset mid-write.
        tick();
        tick();
        wif.winc = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_waddr", 32'(wif.waddr), 32'd3);
        rst = 1'b1;
        #1;
        chk("midrst_write_en", 32'(wif.write_en), 32'd0);
        tick();
        chk("midrst_waddr", 32'(wif.waddr), 32'd0);
        chk("midrst_waddr_gray", 32'(wif.waddr_gray), 32'd0);
        chk("midrst_wcount", 32'(wif.wcount), 32'd0);
        chk("midrst_wfull", 32'(wif.wfull), 32'd0);
        chk("midrst_wovf", 32'(wif.wovf), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_waddr", 32'(wif.waddr), 32'd0);
        chk("post_rst_write_en", 32'(wif.write_en), 32'd1);
        tick();
        chk("post_rst_waddr_gray", 32'(wif.waddr_gray), 32'b001);
        wif.winc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_write_logic
`default_nettype wire
